// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RISC-V M-extension multiply/divide unit.
// One radix-2 step per cycle (shift-add multiply, restoring divide).
// Divide-by-zero and signed-overflow cases bypass the iteration.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous kill of any pending/in-flight operation
//   in_valid/ready  request handshake; in_ready high only in IDLE
//   in_op           funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   in_a, in_b      rs1 / rs2 operands
//   in_tag          sideband tag, returned unchanged on out_tag
//   out_valid/ready result handshake
//   out_result      result; out_zero flags out_result == 0
//   out_tag         tag captured at acceptance
module alu_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]   ONE   = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE2  = (2*XLEN)'(1);
  localparam logic [XLEN-1:0]   S_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  logic              r_sa;
  logic              r_sb;

  // Operand decode at acceptance
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;

  // Iteration datapath
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_mul_hi;
  logic [XLEN-1:0]   w_mul_lo;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_div_hi;
  logic [XLEN-1:0]   w_div_lo;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_c;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign out_zero   = (r_result == '0);

  always_comb begin
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2
    w_a_signed = (in_op == 3'b001) || (in_op == 3'b010) ||
                 (in_op == 3'b100) || (in_op == 3'b110);
    w_b_signed = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
    w_a_neg    = w_a_signed && in_a[XLEN-1];
    w_b_neg    = w_b_signed && in_b[XLEN-1];
    w_a_mag    = w_a_neg ? (~in_a + ONE) : in_a;
    w_b_mag    = w_b_neg ? (~in_b + ONE) : in_b;
    w_b_zero   = (in_b == '0);
    w_ovf      = in_op[2] && !in_op[0] && (in_a == S_MIN) && (in_b == '1);
    w_special  = in_op[2] && (w_b_zero || w_ovf);
    // in_op[1] distinguishes REM/REMU from DIV/DIVU
    w_special_res = '0;
    if (w_b_zero)
      w_special_res = in_op[1] ? in_a : '1;
    else if (w_ovf)
      w_special_res = in_op[1] ? '0 : in_a;
  end

  always_comb begin
    // Multiply: r_hi accumulates, r_lo holds the multiplier shifting out
    // while product low bits shift in from the top.
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_mul_hi = w_sum[XLEN:1];
    w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};
    // Divide: r_hi is the partial remainder, r_lo the dividend shifting
    // out while quotient bits shift in. The remainder stays below the
    // divisor, so the difference always fits in XLEN bits.
    w_shift  = {r_hi, r_lo[XLEN-1]};
    w_ge     = (w_shift >= {1'b0, r_b});
    w_diff   = w_shift[XLEN-1:0] - r_b;
    w_div_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
    w_div_lo = {r_lo[XLEN-2:0], w_ge};

    w_step_hi = r_op[2] ? w_div_hi : w_mul_hi;
    w_step_lo = r_op[2] ? w_div_lo : w_mul_lo;

    w_prod   = {w_mul_hi, w_mul_lo};
    w_prod_c = (r_sa ^ r_sb) ? (~w_prod + ONE2) : w_prod;
    w_quo    = (r_sa ^ r_sb) ? (~w_div_lo + ONE) : w_div_lo;
    w_rem    = r_sa ? (~w_div_hi + ONE) : w_div_hi;

    case (r_op)
      3'b000:                 w_final = w_prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_tag    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_tag <= in_tag;
            r_sa  <= w_a_neg;
            r_sb  <= w_b_neg;
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= in_op[2] ? w_a_mag : w_b_mag;
              r_b     <= in_op[2] ? w_b_mag : w_a_mag;
              r_cnt   <= CNT_W'(XLEN);
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_result <= w_final;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=32): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_alu_muldiv;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int failures = 0;

  alu_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ubl;
    logic [63:0] pv;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ubl = longint'({32'b0, b});
    pv  = '0;
    case (op)
      3'd0: begin pv = {32'b0, a} * {32'b0, b}; return pv[31:0]; end
      3'd1: begin pv = sa * sb;                 return pv[63:32]; end
      3'd2: begin pv = sa * ubl;                return pv[63:32]; end
      3'd3: begin pv = {32'b0, a} * {32'b0, b}; return pv[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; pv = sa / sb; return pv[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; pv = sa % sb; return pv[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  // Called just after a negedge; returns just after the negedge that
  // follows the accepting posedge. Inputs are scrambled afterwards.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input string name);
    chk({name, ".in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0;
    in_op  = 3'($urandom_range(0, 7));
    in_a   = $urandom;
    in_b   = $urandom;
    in_tag = 5'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, ".valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({name, ".ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input string name);
    int lat;
    issue(op, a, b, tag, name);
    wait_valid(lat);
    chk({name, ".latency"}, lat, ref_lat(op, a, b));
    chk({name, ".result"}, out_result, exp);
    chk({name, ".tag"}, {27'b0, out_tag}, {27'b0, tag});
    chk({name, ".zero"}, {31'b0, out_zero}, {31'b0, (exp == 0)});
    chk({name, ".in_ready_done"}, {31'b0, in_ready}, 32'd0);
    retire(name);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [31:0] a, b, hold_res;
    logic [2:0]  op;
    logic [4:0]  tag;

    // Reset state
    #3;
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.result", out_result, 32'd0);
    chk("rst.zero", {31'b0, out_zero}, 32'd1);
    chk("rst.tag", {27'b0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

    // Directed arithmetic
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, "mul");
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, "mulh");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, "mulhu");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, "mulhsu");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, "div");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, "rem");
    run_op(3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       "divu");
    run_op(3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        "remu");
    run_op(3'd7, 32'd5,        32'd5,        5'd9,  32'd0,        "remu_zero");
    // Special cases
    run_op(3'd4, 32'h1234,     32'd0,        5'd10, 32'hFFFFFFFF, "div0");
    run_op(3'd6, 32'h1234,     32'd0,        5'd11, 32'h1234,     "rem0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        "rem_ovf");

    // Backpressure with a competing request that must be ignored
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, "bp");
    wait_valid(lat);
    chk("bp.latency", lat, XLEN + 1);
    hold_res = 32'hFFFFFFFE;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_op = 3'd0; in_a = $urandom; in_b = $urandom; in_tag = 5'd30;
      @(negedge clk);
      chk("bp.hold_result", out_result, hold_res);
      chk("bp.hold_tag", {27'b0, out_tag}, 32'd21);
      chk("bp.hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp.hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp.no_same_cycle_accept", {31'b0, in_ready}, 32'd1);
    chk("bp.valid_drop", {31'b0, out_valid}, 32'd0);
    chk("bp.result_kept", out_result, hold_res);
    chk("bp.tag_kept", {27'b0, out_tag}, 32'd21);
    run_op(3'd5, 32'd1000, 32'd10, 5'd22, 32'd100, "bp.next");

    // Flush in cycle 5 of BUSY
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd23, "flb");
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flb.valid", {31'b0, out_valid}, 32'd0);
    chk("flb.in_ready", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("flb.no_output", {31'b0, seen}, 32'd0);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5'd24, 32'hFFFFFFFF, "flb.next");

    // Request presented together with flush is refused
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd1; in_b = 32'd0; in_tag = 5'd25;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("fli.in_ready", {31'b0, in_ready}, 32'd1);
    chk("fli.valid", {31'b0, out_valid}, 32'd0);

    // Flush drops a DONE result even with out_ready high
    issue(3'd4, 32'd9, 32'd0, 5'd26, "fld");
    wait_valid(lat);
    chk("fld.latency", lat, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("fld.valid", {31'b0, out_valid}, 32'd0);
    chk("fld.in_ready", {31'b0, in_ready}, 32'd1);

    // Asynchronous reset mid-BUSY
    issue(3'd5, 32'hDEADBEEF, 32'd3, 5'd27, "rmid");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid.valid", {31'b0, out_valid}, 32'd0);
    chk("rmid.result", out_result, 32'd0);
    chk("rmid.zero", {31'b0, out_zero}, 32'd1);
    chk("rmid.tag", {27'b0, out_tag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("rmid.no_output", {31'b0, seen}, 32'd0);
    run_op(3'd6, 32'hFFFFFF9C, 32'd7, 5'd28, 32'hFFFFFFFE, "rmid.next");

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      tag = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(op, a, b, tag, ref_res(op, a, b), $sformatf("rnd%0d.op%0d", n, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Iterative multiply/divide unit with a valid/ready handshake. It is the sequential successor to the single-cycle integer ALU, and implements the RISC-V M-extension operations at a parametrised datapath width. It sits beside the ALU in the execute stage. The pipeline stalls while the unit is busy, and flushes it on a branch mispredict or trap.

Parameters:
XLEN, 32, datapath width; must be even and >= 8.
TAG_W, 5, width of the sideband tag (the destination register index), carried from input to output unchanged.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of any in-flight or pending operation.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept a request.
in_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
in_a  input  XLEN  operand rs1 (multiplicand or dividend).
in_b  input  XLEN  operand rs2 (multiplier or divisor).
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out_result  output  XLEN  result.
out_zero  output  1  high when out_result == 0.
out_tag  output  TAG_W  tag captured at acceptance.

Behaviour:
- Reset is asynchronous on rst_n low.
  - State goes to IDLE.
  - out_valid = 0, out_result = 0, out_tag = 0, internal counter = 0.
  - out_zero follows out_result, so it resets to 1.
  - in_ready = 1 once out of reset.
  - Reset mid-operation discards the operation with no output.
- There are three states: IDLE, BUSY, DONE. in_ready = (state == IDLE).
- IDLE:
  - A request is accepted on an edge where in_valid && in_ready && !flush.
  - On acceptance, the unit latches the operation, the tag and the operand magnitudes and signs.
  - Sign handling by operation:
    - MULH, DIV, REM: both operands are signed.
    - MULHSU: in_a is signed, in_b is unsigned.
    - All other operations: both operands are unsigned.
  - Special cases go to DONE on the next edge with a fixed result (latency 1):
    - DIV or DIVU with in_b = 0: result is all ones.
    - REM or REMU with in_b = 0: result is in_a.
    - DIV with in_a = most-negative and in_b = -1: result is in_a.
    - REM with in_a = most-negative and in_b = -1: result is 0.
  - Every other operation goes to BUSY, with the counter loaded with XLEN.
- BUSY:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. The counter decrements each step.
  - On the step where the counter reaches 1, the unit applies sign correction and goes to DONE. That is exactly XLEN edges in BUSY.
  - out_valid is therefore first high XLEN+1 cycles after the accepting edge.
- Arithmetic:
  - The multiply product is 2*XLEN bits and is two's-complement corrected.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
- DONE:
  - out_valid = 1. out_result and out_tag are held stable until out_ready.
  - On an edge with out_ready = 1, the unit returns to IDLE and out_valid drops. out_result and out_tag keep their last value.
  - No new request is accepted in the same cycle as out_ready; back-to-back issue has a 1-cycle bubble.
- flush:
  - flush = 1 on any edge forces IDLE and out_valid = 0. A DONE result is dropped even if out_ready is high.
  - flush has priority over acceptance. A request presented together with flush is not accepted.
- Inputs other than the handshake are ignored outside IDLE. Operands may change freely after acceptance.

Test Plan:
- XLEN=32. MUL 7 x 0xFFFFFFFD (-3) -> out_result 0xFFFFFFEB, out_valid exactly 33 cycles after acceptance, out_zero 0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM -> 0xFFFFFFFF (33 cycles each). DIVU 100 / 7 -> 14, REMU -> 2. REMU 5 / 5 -> 0 with out_zero 1.
- Special cases, each with out_valid 1 cycle after acceptance:
  - DIV 0x1234 / 0 -> 0xFFFFFFFF.
  - REM 0x1234 / 0 -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_result and out_tag stay stable and in_ready stays 0. Then pulse out_ready -> IDLE, with the next request accepted one cycle later.
- flush asserted in cycle 5 of BUSY -> IDLE next edge, no out_valid, next operation correct. rst_n pulled low mid-BUSY -> outputs reset immediately (asynchronously), and the unit is usable after release.
